// File: rtl/beq_pkg.sv
// Event byte field layout and default sizing shared by the button event queue.
package beq_pkg;

    localparam int VALID_BIT   = 7;
    localparam int OVF_BIT     = 6;
    localparam int ID_LSB      = 0;
    localparam int ID_W        = 4;
    localparam int DEF_DEPTH   = 8;
    localparam int DEF_NUM_BTN = 4;

    function automatic logic [7:0] make_evt_byte(input logic valid,
                                                 input logic ovf,
                                                 input logic [ID_W-1:0] id);
        logic [7:0] b;
        b                 = '0;
        b[VALID_BIT]      = valid;
        b[OVF_BIT]        = ovf;
        b[ID_LSB +: ID_W] = id;
        return b;
    endfunction

endpackage

// File: rtl/beq_fifo.sv
// Synchronous FIFO with one-cycle push/pop; a push is accepted while full only
// when a pop happens in the same cycle. Pointers carry an extra wrap bit.
module beq_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop    = pop_i && !empty_o;
    assign do_push   = push_i && (!full_o || do_pop);
    assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end

endmodule

// File: rtl/button_event_queue.sv
// Latches button press pulses as pending bits and queues IDs lowest-first; rd_req pops with a
// registered one-cycle-later byte. Sticky loss flag ovf exists only when BEQ_OVF_DETECT_EN is defined.
module button_event_queue
    import beq_pkg::*;
#(
    parameter int NUM_BTN = DEF_NUM_BTN,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_evt,
    input  logic               rd_req,
    input  logic               ovf_clr,
    output logic [7:0]         rd_data,
    output logic               rd_valid,
    output logic               empty,
    output logic               full,
    output logic               ovf,
    output logic               irq
);
    logic [NUM_BTN-1:0] pending_q, pending_d, grant_mask;
    logic [ID_W-1:0]    grant_id, head_id;
    logic               grant_vld, push, pop;
    logic [7:0]         rd_data_q, rd_data_d;
    logic               rd_valid_q;

    beq_fifo #(.WIDTH(ID_W), .DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_dat_i (grant_id),
        .pop_i      (pop),
        .pop_dat_o  (head_id),
        .full_o     (full),
        .empty_o    (empty)
    );

    assign pop = rd_req && !empty;

    // Lowest index wins: scan from the top so the last hit is the smallest ID.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                grant_vld = 1'b1;
                grant_id  = ID_W'(i);
            end
        end
        push       = grant_vld && (!full || pop);
        grant_mask = push ? (NUM_BTN'(1) << grant_id) : '0;
        pending_d  = (pending_q & ~grant_mask) | btn_evt;
    end

`ifdef BEQ_OVF_DETECT_EN
    logic ovf_q, ovf_d, lost;

    always_comb begin
        lost  = |(btn_evt & pending_q & ~grant_mask);
        ovf_d = lost | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf            = 1'b0;
`endif

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_req) rd_data_d = make_evt_byte(!empty, ovf, empty ? '0 : head_id);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_req;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign irq      = !empty | ovf;

endmodule

// File: tb/tb_button_event_queue.sv
// Directed and random stimulus for button_event_queue against a queue-based reference model.
module tb_button_event_queue;

`ifdef BEQ_OVF_DETECT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn_evt;
    logic       rd_req, ovf_clr;
    logic [7:0] rd_data;
    logic       rd_valid, empty, full, ovf, irq;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    int         exp_q[$];
    bit [3:0]   exp_pend;
    bit         exp_ovf;
    logic [7:0] exp_rd_data;
    bit         exp_rd_valid;

    button_event_queue #(.NUM_BTN(4), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_evt  (btn_evt),
        .rd_req   (rd_req),
        .ovf_clr  (ovf_clr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .ovf      (ovf),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_pend     = '0;
        exp_ovf      = 1'b0;
        exp_rd_data  = 8'h00;
        exp_rd_valid = 1'b0;
    endtask

    // One clock of the queue described in plain terms: pop, then lowest pending
    // goes in if there is room, then new pulses land (a pulse on a still-pending button is lost).
    task automatic model_step(input logic [3:0] b, input logic r, input logic c);
        int  gid;
        bit  lost;
        exp_rd_valid = r;
        if (r) begin
            if (exp_q.size() > 0) begin
                exp_rd_data = {1'b1, exp_ovf, 2'b00, 4'(exp_q[0])};
                void'(exp_q.pop_front());
            end else begin
                exp_rd_data = {1'b0, exp_ovf, 6'b0};
            end
        end
        gid = -1;
        if (exp_q.size() < DEPTH) begin
            for (int i = 0; i < 4; i++) begin
                if (exp_pend[i]) begin
                    gid = i;
                    break;
                end
            end
        end
        if (gid >= 0) begin
            exp_q.push_back(gid);
            exp_pend[gid] = 1'b0;
        end
        lost = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                if (exp_pend[i]) lost = 1'b1;
                exp_pend[i] = 1'b1;
            end
        end
        if (OVF_EN) begin
            if (lost)   exp_ovf = 1'b1;
            else if (c) exp_ovf = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("rd_data",  rd_data,        exp_rd_data);
        chk("rd_valid", {7'b0, rd_valid}, {7'b0, exp_rd_valid});
        chk("empty",    {7'b0, empty},  {7'b0, exp_q.size() == 0});
        chk("full",     {7'b0, full},   {7'b0, exp_q.size() == DEPTH});
        chk("ovf",      {7'b0, ovf},    {7'b0, exp_ovf});
        chk("irq",      {7'b0, irq},    {7'b0, (exp_q.size() != 0) || exp_ovf});
    endtask

    task automatic tick(input logic [3:0] b, input logic r, input logic c);
        btn_evt = b;
        rd_req  = r;
        ovf_clr = c;
        @(posedge clk);
        model_step(b, r, c);
        #1;
        btn_evt = '0;
        rd_req  = 1'b0;
        ovf_clr = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(4'b0000, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] byte_exp;
        rst_n   = 1'b0;
        btn_evt = '0;
        rd_req  = 1'b0;
        ovf_clr = 1'b0;
        model_reset();
        #12;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single press on button 2, read five cycles later
        tick(4'b0100, 1'b0, 1'b0);
        idle(4);
        chk("irq_before_read", {7'b0, irq}, 8'h01);
        tick(4'b0000, 1'b1, 1'b0);
        chk("single_byte", rd_data, 8'h82);
        chk("single_valid", {7'b0, rd_valid}, 8'h01);
        idle(1);
        chk("single_valid_drop", {7'b0, rd_valid}, 8'h00);
        chk("single_hold", rd_data, 8'h82);
        chk("single_irq_low", {7'b0, irq}, 8'h00);

        // Simultaneous presses drain in ascending ID order
        tick(4'b1011, 1'b0, 1'b0);
        idle(5);
        tick(4'b0000, 1'b1, 1'b0);
        chk("multi_0", rd_data, 8'h80);
        tick(4'b0000, 1'b1, 1'b0);
        chk("multi_1", rd_data, 8'h81);
        tick(4'b0000, 1'b1, 1'b0);
        chk("multi_3", rd_data, 8'h83);
        idle(1);

        // Read while empty
        tick(4'b0000, 1'b1, 1'b0);
        chk("empty_read", rd_data, 8'h00);
        chk("empty_read_valid", {7'b0, rd_valid}, 8'h01);
        chk("empty_read_still_empty", {7'b0, empty}, 8'h01);

        // Overfill button 1: eight queued, ninth pending, tenth lost
        for (int k = 0; k < 9; k++) begin
            tick(4'b0010, 1'b0, 1'b0);
            idle(2);
        end
        chk("fill_full", {7'b0, full}, 8'h01);
        chk("fill_pending1", {7'b0, dut.pending_q[1]}, {7'b0, exp_pend[1]});
        chk("fill_no_ovf", {7'b0, ovf}, 8'h00);
        tick(4'b0010, 1'b0, 1'b0);
        idle(1);
        chk("tenth_ovf", {7'b0, ovf}, {7'b0, OVF_EN});
        byte_exp = OVF_EN ? 8'hC1 : 8'h81;
        for (int k = 0; k < 9; k++) begin
            tick(4'b0000, 1'b1, 1'b0);
            chk("drain_byte", rd_data, byte_exp);
            idle(1);
        end
        chk("drain_empty", {7'b0, empty}, 8'h01);
        tick(4'b0000, 1'b0, 1'b1);
        chk("ovf_cleared", {7'b0, ovf}, 8'h00);

        // Press and pop together at full: occupancy returns to eight, button 2 at tail
        for (int k = 0; k < 8; k++) begin
            tick(4'b0001, 1'b0, 1'b0);
            idle(1);
        end
        chk("fill2_full", {7'b0, full}, 8'h01);
        tick(4'b0100, 1'b1, 1'b0);
        idle(2);
        chk("push_pop_full", {7'b0, full}, 8'h01);
        chk("push_pop_no_ovf", {7'b0, ovf}, 8'h00);
        for (int k = 0; k < 8; k++) tick(4'b0000, 1'b1, 1'b0);
        chk("tail_btn2", rd_data, 8'h82);
        idle(1);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            tick(($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 15) == 0);
        end
        for (int k = 0; k < 12; k++) tick(4'b0000, 1'b1, 1'b1);

        // Reset mid-operation with three queued entries
        tick(4'b0111, 1'b0, 1'b0);
        idle(4);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        #2;
        rst_n = 1'b1;
        tick(4'b1000, 1'b0, 1'b0);
        idle(2);
        chk("post_reset_accept", {7'b0, empty}, 8'h00);
        tick(4'b0000, 1'b1, 1'b0);
        chk("post_reset_byte", rd_data, 8'h83);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/button_event_queue.md
BUTTON_EVENT_QUEUE -- requirements
Module: button_event_queue

Interface
REQ-001 Parameter NUM_BTN, default 4: number of debounced button event inputs, legal range 1..16.
REQ-002 Parameter DEPTH, default 8: FIFO entries, power of two, legal range 2..64.
REQ-003 clk  input  1  system clock, 50 MHz; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 btn_evt  input  NUM_BTN  one-cycle press pulses, one per debouncer; bit i is button i.
REQ-006 rd_req  input  1  one-cycle pop request from the I2C slave register read path.
REQ-007 rd_data  output  8  event byte: bit7 valid, bit6 overflow snapshot, bits5:4 zero, bits3:0 button ID.
REQ-008 rd_valid  output  1  one-cycle strobe marking rd_data updated.
REQ-009 empty  output  1  FIFO holds zero entries.
REQ-010 full  output  1  FIFO holds DEPTH entries.
REQ-011 ovf  output  1  sticky lost-event flag.
REQ-012 ovf_clr  input  1  one-cycle clear of ovf.
REQ-013 irq  output  1  level interrupt to host, equal to !empty | ovf.

Function
REQ-014 Each button has a pending bit, set on the cycle after btn_evt[i]=1.
REQ-015 Arbiter enqueues the lowest-index pending button each cycle when the FIFO is not full, or when full and a pop occurs in the same cycle, clearing that pending bit.
REQ-016 Pulses on several btn_evt bits in one cycle are all captured, then enqueued in ascending ID order, one per cycle.
REQ-017 btn_evt[i] arriving while pending[i] is already set is a lost event; the pending bit stays set and the queue receives exactly one entry.
REQ-018 btn_evt[i] arriving in the same cycle pending[i] is enqueued re-sets pending[i]; no loss.
REQ-019 Full FIFO: pending bits hold, no entry is overwritten, and nothing is dropped except under REQ-017.
REQ-020 rd_req with !empty pops the head; next cycle rd_data={1,ovf,2'b00,ID} and rd_valid=1.
REQ-021 rd_req with empty: next cycle rd_data=8'h00 (bit6 = ovf), rd_valid=1, FIFO unchanged.
REQ-022 rd_data holds its value until the next rd_req; rd_valid is high for exactly one cycle per rd_req.
REQ-023 Enqueue and pop in the same cycle leave occupancy unchanged, including at full and at one entry.
REQ-024 Read/write pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full and empty are decoded from the MSB and index compare.
REQ-025 Simultaneous loss event and ovf_clr: ovf ends the cycle set (set wins).

Reset
REQ-026 While rst_n=0: pointers=0, pending=0, rd_data=8'h00, rd_valid=0, ovf=0, empty=1, full=0, irq=0.
REQ-027 Reset mid-operation discards all queued and pending events; the first event after release is accepted on the first rising clk.

Configuration
REQ-028 Macro BEQ_OVF_DETECT_EN: when defined, REQ-011/017/025 behave as stated; when undefined, ovf is tied 0, rd_data bit6 is 0, irq=!empty, ovf_clr is ignored, and loss detection logic is absent.

Structure
REQ-029 Package beq_pkg holds the event byte field positions (VALID_BIT=7, OVF_BIT=6, ID_LSB=0, ID_W=4) and default DEPTH/NUM_BTN constants.
REQ-030 Storage is sub-module beq_fifo (synchronous FIFO, width 4, parameter DEPTH, push/pop/full/empty); arbiter, pending, and read register live in the top level.

Verification
REQ-031 Reset released, pulse btn_evt=4'b0100, then rd_req 5 cycles later -> rd_data=8'h82, rd_valid one cycle, empty=1 afterwards, irq 1->0.
REQ-032 btn_evt=4'b1011 in one cycle, then 3 rd_req -> rd_data sequence 8'h80, 8'h81, 8'h83.
REQ-033 DEPTH=8: 9 spaced pulses on button 1, no reads -> full=1, pending[1]=1, ovf=0; 10th pulse -> ovf=1; read 9 -> nine 8'hC1 bytes (bit6 set), then empty.
REQ-034 rd_req while empty -> rd_data=8'h00, rd_valid=1, pointers unchanged.
REQ-035 FIFO full, btn_evt[2] and rd_req in the same cycle -> occupancy stays 8, button 2 entry appears at the tail, no ovf.
REQ-036 Three entries queued, rst_n pulsed low mid-cycle -> outputs immediately take REQ-026 values; build without BEQ_OVF_DETECT_EN repeats REQ-033 with ovf=0 and bytes 8'h81.
